booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq.sv | 173 +++++++++++++++++
 tb/tb_booth_mult_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: signed 32x32 -> 64-bit product, one Booth
// step per clock through a single 32-bit adder, with a start/busy/done handshake.

module adder (
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] total;

    assign total = {1'b0, ra} + {1'b0, rb} + {32'b0, cin};
    assign sum   = total[31:0];
    assign cout  = total[32];
endmodule

module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] add_ra;
    logic [WIDTH-1:0] add_rb;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             step_sign;
    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_q;
    logic             step_q1;

    // Booth operand select from the current pair {Q[0], q_1}.
    always_comb begin
        add_ra  = a_q;
        add_rb  = '0;
        add_cin = 1'b0;
        unique case ({q_q[0], q1_q})
            2'b01: add_rb = m_q;
            2'b10: begin
                add_rb  = ~m_q;
                add_cin = 1'b1;
            end
            default: begin
                add_rb  = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    adder u_adder (
        .ra   (add_ra),
        .rb   (add_rb),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The true 33rd bit of A +/- M comes from the operand signs and the carry
    // out; sum[31] alone overflows when M is the most negative value.
    always_comb begin
        step_sign = add_ra[WIDTH-1] ^ add_rb[WIDTH-1] ^ add_cout;
        step_a    = {step_sign, add_sum[WIDTH-1:1]};
        step_q    = {add_sum[0], q_q[WIDTH-1:1]};
        step_q1   = q_q[0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = step_a;
                q_d     = step_q;
                q1_d    = step_q1;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    hi_d    = step_a;
                    lo_d    = step_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector bench for booth_mult_seq: product values, latency, handshake,
// ignored start while running, accept from DONE and asynchronous reset.

module tb_booth_mult_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int failed;

    booth_mult_seq #(
        .WIDTH (32),
        .STEPS (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] mc;
        logic [31:0] mp;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Counts edges after acceptance until done rises, up to a bound.
    task automatic wait_done(output int n, output bit busy_ok, output bit hold_ok,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
        n       = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [31:0] mc, input logic [31:0] mp,
                         input logic [31:0] eh, input logic [31:0] el, input int tag);
        int          n;
        bit          busy_ok;
        bit          hold_ok;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        @(negedge clk);
        multiplicand = mc;
        multiplier   = mp;
        start        = 1'b1;
        old_hi       = hi;
        old_lo       = lo;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d accept busy/done", tag), {62'b0, busy, done}, 64'd2);
        wait_done(n, busy_ok, hold_ok, old_hi, old_lo);
        chk($sformatf("v%0d latency", tag), 64'(n), 64'd32);
        chk($sformatf("v%0d busy while running", tag), {63'b0, busy_ok}, 64'd1);
        chk($sformatf("v%0d hi/lo held while running", tag), {63'b0, hold_ok}, 64'd1);
        chk($sformatf("v%0d product", tag), {hi, lo}, {eh, el});
        chk($sformatf("v%0d done busy", tag), {62'b0, busy, done}, 64'd1);
    endtask

    initial begin
        int          n;
        bit          busy_ok;
        bit          hold_ok;

        tests        = 0;
        failed       = 0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0]  = '{32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
        vecs[1]  = '{32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[3]  = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};
        vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[7]  = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[9]  = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {30'b0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle without start", {30'b0, busy, done, hi, lo}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].mc, vecs[i].mp, vecs[i].exp_hi, vecs[i].exp_lo, i);
        end

        // start while running: second request must be ignored
        @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignored start busy", {63'b0, busy}, 64'd1);
        wait_done(n, busy_ok, hold_ok, 32'h80000000 ^ 32'h40000000, 32'h80000000);
        chk("ignored start latency", 64'(n + 11), 64'd32);
        chk("ignored start product", {hi, lo}, 64'd6);

        // accept from DONE: done drops on the accept edge, hi/lo hold
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done-accept flags", {62'b0, busy, done}, 64'd2);
        chk("done-accept hold", {hi, lo}, 64'd6);
        wait_done(n, busy_ok, hold_ok, 32'd0, 32'd6);
        chk("done-accept latency", 64'(n), 64'd32);
        chk("done-accept hold while running", {63'b0, hold_ok}, 64'd1);
        chk("done-accept product", {hi, lo}, 64'h51);

        // asynchronous reset mid-operation
        @(negedge clk);
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {30'b0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post-reset idle", {62'b0, busy, done}, 64'd0);
        do_op(32'd4, 32'd4, 32'd0, 32'h10, 99);

        // back-to-back: start held high through DONE re-accepts next edge
        @(negedge clk);
        multiplicand = 32'd3;
        multiplier   = 32'd3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n, busy_ok, hold_ok, 32'd0, 32'h10);
        chk("b2b first product", {hi, lo}, 64'd9);
        @(posedge clk);
        #1;
        chk("b2b re-accept flags", {62'b0, busy, done}, 64'd2);
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
